// File: rtl/bb_lpf_pkg.sv
// Shared constants, FSM state type and round/saturate helper for the baseband low-pass filter.
package bb_lpf_pkg;

  localparam int NTAPS  = 8;
  localparam int NPAIRS = NTAPS / 2;
  localparam int IN_W   = 8;
  localparam int CW     = 7;
  localparam int ACC_W  = 20;
  localparam int ROUND  = 64;
  localparam int SHIFT  = 7;

  localparam logic signed [CW-1:0] COEF [NTAPS] = '{
    7'sd2, 7'sd9, 7'sd21, 7'sd32, 7'sd32, 7'sd21, 7'sd9, 7'sd2
  };

  localparam logic signed [ACC_W-1:0] OUT_MAX = 20'sh0007F;
  localparam logic signed [ACC_W-1:0] OUT_MIN = 20'shFFF80;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  function automatic logic signed [IN_W-1:0] round_sat(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] sh;
    logic signed [IN_W-1:0]  res;
    sh = (acc + ACC_W'(ROUND)) >>> SHIFT;
    if (sh > OUT_MAX) begin
      res = 8'sh7F;
    end else if (sh < OUT_MIN) begin
      res = 8'sh80;
    end else begin
      res = sh[IN_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/bb_lpf_if.sv
// Sample-in / filtered-out bundle between the demodulator side and bb_lpf.
interface bb_lpf_if;
  import bb_lpf_pkg::*;

  logic                   sample_ready;
  logic signed [IN_W-1:0] I_BB_prefilter;
  logic signed [IN_W-1:0] Q_BB_prefilter;
  logic signed [IN_W-1:0] I_BB;
  logic signed [IN_W-1:0] Q_BB;
  logic                   bb_valid;
  logic                   busy;
  logic                   overrun;

  modport master (
    output sample_ready, I_BB_prefilter, Q_BB_prefilter,
    input  I_BB, Q_BB, bb_valid, busy, overrun
  );

  modport slave (
    input  sample_ready, I_BB_prefilter, Q_BB_prefilter,
    output I_BB, Q_BB, bb_valid, busy, overrun
  );

endinterface

// File: rtl/bb_lpf_mac.sv
// One filter channel: delay line, symmetric pre-adder, coefficient multiply,
// accumulator and rounded/saturated output register.
module bb_lpf_mac
  import bb_lpf_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   shift_en_i,
  input  logic                   clr_i,
  input  logic                   mac_en_i,
  input  logic                   load_i,
  input  logic [1:0]             idx_i,
  input  logic signed [IN_W-1:0] din_i,
  output logic signed [IN_W-1:0] dout_o
);

  logic signed [IN_W-1:0]  tap_q [NTAPS];
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [IN_W-1:0]  out_q;
  logic signed [IN_W:0]    pre_s;
  logic signed [IN_W+CW:0] prod_s;
  logic [2:0]              idx_lo_s;
  logic [2:0]              idx_hi_s;

  // Tap pair k and 7-k share coefficient k, so one multiply per pair.
  always_comb begin
    idx_lo_s = {1'b0, idx_i};
    idx_hi_s = 3'd7 - idx_lo_s;
    pre_s    = {tap_q[idx_lo_s][IN_W-1], tap_q[idx_lo_s]}
             + {tap_q[idx_hi_s][IN_W-1], tap_q[idx_hi_s]};
    prod_s   = pre_s * COEF[idx_lo_s];
    acc_d    = acc_q + ACC_W'(prod_s);
  end

  // Delay line, accumulator and output register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NTAPS; i++) begin
        tap_q[i] <= {IN_W{1'b0}};
      end
      acc_q <= {ACC_W{1'b0}};
      out_q <= {IN_W{1'b0}};
    end else begin
      if (shift_en_i) begin
        tap_q[0] <= din_i;
        for (int i = 1; i < NTAPS; i++) begin
          tap_q[i] <= tap_q[i-1];
        end
      end
      if (clr_i) begin
        acc_q <= {ACC_W{1'b0}};
      end else if (mac_en_i) begin
        acc_q <= acc_d;
      end
      if (load_i) begin
        out_q <= round_sat(acc_d);
      end
    end
  end

  assign dout_o = out_q;

endmodule

// File: rtl/bb_lpf.sv
// Baseband I/Q 8-tap symmetric FIR low-pass with IDLE/MAC/OUT sequencer.
// Optional macro BB_LPF_DECIM2_EN: decimate by two (every other accepted sample computes an output).
module bb_lpf
  import bb_lpf_pkg::*;
(
  input logic    clk,
  input logic    reset_n,
  bb_lpf_if.slave bus
);

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic       overrun_q, overrun_d;
  logic       bb_valid_q, bb_valid_d;
  logic       busy_q, busy_d;
  logic       accept_s;
  logic       launch_s;
  logic       mac_en_s;
  logic       load_s;
`ifdef BB_LPF_DECIM2_EN
  logic       phase_q, phase_d;
`endif

  // Sequencer next state; a sample is taken whenever the MAC is not running.
  always_comb begin
    accept_s   = bus.sample_ready && (state_q != ST_MAC);
`ifdef BB_LPF_DECIM2_EN
    launch_s   = accept_s && !phase_q;
    phase_d    = accept_s ? ~phase_q : phase_q;
`else
    launch_s   = accept_s;
`endif
    state_d    = state_q;
    idx_d      = idx_q;
    mac_en_s   = 1'b0;
    load_s     = 1'b0;
    overrun_d  = overrun_q | (bus.sample_ready && (state_q == ST_MAC));
    case (state_q)
      ST_IDLE: begin
        if (launch_s) begin
          state_d = ST_MAC;
          idx_d   = 2'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MAC: begin
        mac_en_s = 1'b1;
        if (idx_q == 2'd3) begin
          state_d = ST_OUT;
          idx_d   = 2'd0;
          load_s  = 1'b1;
        end else begin
          idx_d   = idx_q + 2'd1;
        end
      end
      ST_OUT: begin
        if (launch_s) begin
          state_d = ST_MAC;
          idx_d   = 2'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 2'd0;
      end
    endcase
    bb_valid_d = (state_d == ST_OUT);
    busy_d     = (state_d == ST_MAC);
  end

  // Sequencer state and status registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= 2'd0;
      overrun_q  <= 1'b0;
      bb_valid_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef BB_LPF_DECIM2_EN
      phase_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      overrun_q  <= overrun_d;
      bb_valid_q <= bb_valid_d;
      busy_q     <= busy_d;
`ifdef BB_LPF_DECIM2_EN
      phase_q    <= phase_d;
`endif
    end
  end

  assign bus.bb_valid = bb_valid_q;
  assign bus.busy     = busy_q;
  assign bus.overrun  = overrun_q;

  bb_lpf_mac u_mac_i (
    .clk        (clk),
    .reset_n    (reset_n),
    .shift_en_i (accept_s),
    .clr_i      (accept_s),
    .mac_en_i   (mac_en_s),
    .load_i     (load_s),
    .idx_i      (idx_q),
    .din_i      (bus.I_BB_prefilter),
    .dout_o     (bus.I_BB)
  );

  bb_lpf_mac u_mac_q (
    .clk        (clk),
    .reset_n    (reset_n),
    .shift_en_i (accept_s),
    .clr_i      (accept_s),
    .mac_en_i   (mac_en_s),
    .load_i     (load_s),
    .idx_i      (idx_q),
    .din_i      (bus.Q_BB_prefilter),
    .dout_o     (bus.Q_BB)
  );

endmodule

// File: doc/bb_lpf.md
BB_LPF -- requirements
Module: bb_lpf

Interface
REQ-001 SHALL have parameter-free ports; all constants come from bb_lpf_pkg.
REQ-002 clk  in  1  system clock (50 MHz); all logic on rising edge.
REQ-003 reset_n  in  1  reset, synchronous, active-low.
REQ-004 sample_ready  in  1  one-cycle strobe; I/Q prefilter inputs valid this cycle.
REQ-005 I_BB_prefilter  in  8  signed two's-complement baseband I from demodulator.
REQ-006 Q_BB_prefilter  in  8  signed two's-complement baseband Q from demodulator.
REQ-007 I_BB  out  8  signed filtered I, registered.
REQ-008 Q_BB  out  8  signed filtered Q, registered.
REQ-009 bb_valid  out  1  one-cycle strobe; I_BB/Q_BB updated this cycle.
REQ-010 busy  out  1  high while in MAC state.
REQ-011 overrun  out  1  sticky; sample arrived while busy.

Function
REQ-012 SHALL implement per channel an 8-tap symmetric FIR, coefficients C = {2,9,21,32,32,21,9,2} (sum 128).
REQ-013 Delay line: 8 x 8-bit signed per channel; on accepted sample, shift in new value at tap 0; shift at most once per accepted sample.
REQ-014 Sample accepted when sample_ready=1 and state is IDLE or OUT; the delay line shifts on that edge.
REQ-015 FSM states IDLE, MAC, OUT: IDLE->MAC on accept; MAC holds 4 cycles (pair index 0..3); MAC->OUT after index 3; OUT->MAC on accept in same cycle, else OUT->IDLE.
REQ-016 Each MAC cycle k: pre-add d[k]+d[7-k] (9-bit signed), multiply by C[k], accumulate into 20-bit signed accumulator; accumulator cleared on accept.
REQ-017 Output = (acc + 64) >>> 7 (arithmetic), saturated to [-128,127]; registered into I_BB/Q_BB on MAC->OUT edge.
REQ-018 bb_valid high exactly during OUT; latency: accept at edge t -> bb_valid high in cycle t+5.
REQ-019 Minimum accepted sample spacing 5 cycles; sample_ready during MAC SHALL be dropped (delay line unchanged) and SHALL set overrun.
REQ-020 I_BB/Q_BB SHALL hold value between bb_valid pulses.

Reset
REQ-021 On reset_n=0 at clk edge: state IDLE, delay lines 0, accumulators 0, I_BB=0, Q_BB=0, bb_valid=0, busy=0, overrun=0.
REQ-022 Reset during MAC SHALL abort computation; no bb_valid issued for that sample.
REQ-023 overrun cleared only by reset.

Configuration
REQ-024 Macro BB_LPF_DECIM2_EN: when defined, phase bit (0 after reset) toggles per accepted sample; MAC launched only for accepts with phase=0; phase=1 accepts shift the delay line and return/stay IDLE or OUT->IDLE without bb_valid.
REQ-025 Without BB_LPF_DECIM2_EN, every accepted sample launches MAC (full rate output).

Structure
REQ-026 bb_lpf_pkg SHALL hold NTAPS=8, IN_W=8, ACC_W=20, COEF array, ROUND=64, SHIFT=7, and the state enum typedef.
REQ-027 Sub-module bb_lpf_mac (one channel: delay line, pre-adder, multiplier, accumulator, round/saturate) SHALL be instantiated twice (I, Q); FSM lives in bb_lpf.

Verification
REQ-028 Reset: hold reset_n=0 3 cycles with random inputs -> all outputs 0, no bb_valid.
REQ-029 Impulse: I=127 once then I=0, Q=0, spacing 5 -> I_BB sequence 2,9,21,32,32,21,9,2 then 0; Q_BB=0 throughout.
REQ-030 DC: I=100, Q=-128 constant, spacing 5 -> from 8th output on I_BB=100, Q_BB=-128.
REQ-031 Latency/overrun: sample_ready at t, again at t+3 -> bb_valid at t+5 only, second sample dropped, overrun=1 from t+4.
REQ-032 Reset mid-MAC: reset_n=0 at t+2 after accept -> no bb_valid, outputs 0, delay line cleared.
REQ-033 With BB_LPF_DECIM2_EN: 4 accepted samples spacing 5 -> exactly 2 bb_valid pulses, after 1st and 3rd samples.
